// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and broadcast register for the common data bus.
// Up to four functional-unit result ports compete each cycle. The single winner
// is acknowledged combinationally on accept. Its label and data are registered
// and broadcast on BCEN/BClabel/BCdata during the following cycle.
module cdb_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4,
    parameter int NREQ    = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic [NREQ-1:0]    require,
    input  logic [DATA_W-1:0]  data0,
    input  logic [DATA_W-1:0]  data1,
    input  logic [DATA_W-1:0]  data2,
    input  logic [DATA_W-1:0]  data3,
    input  logic [LABEL_W-1:0] label0,
    input  logic [LABEL_W-1:0] label1,
    input  logic [LABEL_W-1:0] label2,
    input  logic [LABEL_W-1:0] label3,
    input  logic               bc_stall,
    output logic [NREQ-1:0]    accept,
    output logic               BCEN,
    output logic [LABEL_W-1:0] BClabel,
    output logic [DATA_W-1:0]  BCdata,
    output logic [1:0]         ptr,
    output logic               err_label0
);

    // Per-unit views of the flat result ports
    logic [LABEL_W-1:0] label_s [4];
    logic [DATA_W-1:0]  data_s  [4];
    logic [NREQ-1:0]    elig_s;
    logic [NREQ-1:0]    bad_lbl_s;
    logic               grant_s;
    logic [1:0]         win_s;
    logic [NREQ-1:0]    accept_s;

    // Broadcast and pointer state
    logic [1:0]         ptr_q,     ptr_d;
    logic               bcen_q,    bcen_d;
    logic [LABEL_W-1:0] bclabel_q, bclabel_d;
    logic [DATA_W-1:0]  bcdata_q,  bcdata_d;
    logic               err_q,     err_d;

    // Gather unit inputs into arrays so selection can be indexed
    always_comb begin
        label_s[0] = label0;
        label_s[1] = label1;
        label_s[2] = label2;
        label_s[3] = label3;
        data_s[0]  = data0;
        data_s[1]  = data1;
        data_s[2]  = data2;
        data_s[3]  = data3;
    end

    // Eligibility: a request with label 0 names no producer and is never granted
    always_comb begin
        elig_s    = {NREQ{1'b0}};
        bad_lbl_s = {NREQ{1'b0}};
        for (int i = 0; i < 4; i++) begin
            if (label_s[i] == {LABEL_W{1'b0}}) begin
                bad_lbl_s[i] = require[i];
                elig_s[i]    = 1'b0;
            end else begin
                bad_lbl_s[i] = 1'b0;
                elig_s[i]    = require[i] & ~bc_stall;
            end
        end
    end

    // Round-robin scan starting at the current priority pointer
    always_comb begin
        logic [1:0] idx_v;
        idx_v   = 2'd0;
        grant_s = 1'b0;
        win_s   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx_v = ptr_q + 2'(k);
            if (!grant_s && elig_s[idx_v]) begin
                grant_s = 1'b1;
                win_s   = idx_v;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // One-hot grant, suppressed while reset is held
    always_comb begin
        accept_s = {NREQ{1'b0}};
        if (grant_s) begin
            accept_s[win_s] = 1'b1;
        end else begin
            accept_s = {NREQ{1'b0}};
        end
        if (nRST) begin
            accept = {NREQ{1'b0}};
        end else begin
            accept = accept_s;
        end
    end

    // Next broadcast contents, pointer advance and sticky label-0 error
    always_comb begin
        if (grant_s) begin
            bcen_d    = 1'b1;
            bclabel_d = label_s[win_s];
            bcdata_d  = data_s[win_s];
            ptr_d     = win_s + 2'd1;
        end else begin
            bcen_d    = 1'b0;
            bclabel_d = {LABEL_W{1'b0}};
            bcdata_d  = {DATA_W{1'b0}};
            ptr_d     = ptr_q;
        end
        err_d = err_q | (|bad_lbl_s);
    end

    // State registers; reset drops any in-flight broadcast at once
    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            ptr_q     <= 2'd0;
            bcen_q    <= 1'b0;
            bclabel_q <= {LABEL_W{1'b0}};
            bcdata_q  <= {DATA_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            bcen_q    <= bcen_d;
            bclabel_q <= bclabel_d;
            bcdata_q  <= bcdata_d;
            err_q     <= err_d;
        end
    end

    assign BCEN       = bcen_q;
    assign BClabel    = bclabel_q;
    assign BCdata     = bcdata_q;
    assign ptr        = ptr_q;
    assign err_label0 = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, a reset-in-flight
// sequence and a randomized run against a behavioural model.
module tb_cdb_arbiter;

    logic        clk;
    logic        nRST;
    logic [3:0]  require;
    logic [31:0] data0, data1, data2, data3;
    logic [3:0]  label0, label1, label2, label3;
    logic        bc_stall;
    logic [3:0]  accept;
    logic        BCEN;
    logic [3:0]  BClabel;
    logic [31:0] BCdata;
    logic [1:0]  ptr;
    logic        err_label0;

    int checks;
    int failures;

    cdb_arbiter #(.DATA_W(32), .LABEL_W(4), .NREQ(4)) dut (
        .clk(clk), .nRST(nRST), .require(require),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .label0(label0), .label1(label1), .label2(label2), .label3(label3),
        .bc_stall(bc_stall), .accept(accept), .BCEN(BCEN), .BClabel(BClabel),
        .BCdata(BCdata), .ptr(ptr), .err_label0(err_label0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] lbl;   // {label3,label2,label1,label0}
        logic        stall;
        logic [3:0]  acc;
        logic        bcen;
        logic [3:0]  bclab;
        logic [31:0] bcdat;
        logic [1:0]  ptr;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] req, logic [15:0] lbl, logic stall,
                                logic [3:0] acc, logic bcen, logic [3:0] bclab,
                                logic [31:0] bcdat, logic [1:0] p, logic e);
        vec_t v;
        v.req = req; v.lbl = lbl; v.stall = stall; v.acc = acc; v.bcen = bcen;
        v.bclab = bclab; v.bcdat = bcdat; v.ptr = p; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [15:0] lbl, input logic stall,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        require  = req;
        label0   = lbl[3:0];
        label1   = lbl[7:4];
        label2   = lbl[11:8];
        label3   = lbl[15:12];
        bc_stall = stall;
        data0 = d0; data1 = d1; data2 = d2; data3 = d3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b1;
        drive(4'b0000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        nRST = 1'b0;
    endtask

    // Behavioural reference state for the random phase
    int          m_ptr;
    logic        m_err;

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b1;
        drive(4'b1111, 16'h4321, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        #1;
        chk("rst_accept",  {28'd0, accept}, 32'd0);
        chk("rst_bcen",    {31'd0, BCEN}, 32'd0);
        chk("rst_bclabel", {28'd0, BClabel}, 32'd0);
        chk("rst_bcdata",  BCdata, 32'd0);
        chk("rst_ptr",     {30'd0, ptr}, 32'd0);
        chk("rst_err",     {31'd0, err_label0}, 32'd0);
        do_reset();

        // Directed rows, each one cycle, state carries from row to row
        tbl.push_back(mk(4'b0001, 16'h0003, 1'b0, 4'b0001, 1'b1, 4'd3, 32'h11, 2'd1, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h0003, 1'b0, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1000, 16'h4000, 1'b0, 4'b1000, 1'b1, 4'd4, 32'h44, 2'd0, 1'b0));
        tbl.push_back(mk(4'b1111, 16'h4321, 1'b0, 4'b0001, 1'b1, 4'd1, 32'h11, 2'd1, 1'b0));
        tbl.push_back(mk(4'b1110, 16'h4321, 1'b0, 4'b0010, 1'b1, 4'd2, 32'h22, 2'd2, 1'b0));
        tbl.push_back(mk(4'b1100, 16'h4321, 1'b0, 4'b0100, 1'b1, 4'd3, 32'h33, 2'd3, 1'b0));
        tbl.push_back(mk(4'b1000, 16'h4321, 1'b0, 4'b1000, 1'b1, 4'd4, 32'h44, 2'd0, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h4321, 1'b0, 4'b0010, 1'b1, 4'd2, 32'h22, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0011, 16'h4321, 1'b0, 4'b0001, 1'b1, 4'd1, 32'h11, 2'd1, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h4321, 1'b0, 4'b0010, 1'b1, 4'd2, 32'h22, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd2, 1'b0));
        tbl.push_back(mk(4'b0100, 16'h4321, 1'b0, 4'b0100, 1'b1, 4'd3, 32'h33, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd3, 1'b0));
        tbl.push_back(mk(4'b0010, 16'h4301, 1'b0, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd3, 1'b1));
        tbl.push_back(mk(4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b0, 4'd0, 32'h00, 2'd3, 1'b1));
        tbl.push_back(mk(4'b0001, 16'h4321, 1'b0, 4'b0001, 1'b1, 4'd1, 32'h11, 2'd1, 1'b1));
        tbl.push_back(mk(4'b0011, 16'h4301, 1'b0, 4'b0001, 1'b1, 4'd1, 32'h11, 2'd1, 1'b1));

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            drive(tbl[r].req, tbl[r].lbl, tbl[r].stall, 32'h11, 32'h22, 32'h33, 32'h44);
            #1;
            chk($sformatf("vec%0d_accept", r), {28'd0, accept}, {28'd0, tbl[r].acc});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_bcen", r), {31'd0, BCEN}, {31'd0, tbl[r].bcen});
            chk($sformatf("vec%0d_bclabel", r), {28'd0, BClabel}, {28'd0, tbl[r].bclab});
            chk($sformatf("vec%0d_bcdata", r), BCdata, tbl[r].bcdat);
            chk($sformatf("vec%0d_ptr", r), {30'd0, ptr}, {30'd0, tbl[r].ptr});
            chk($sformatf("vec%0d_err", r), {31'd0, err_label0}, {31'd0, tbl[r].err});
        end

        // Reset while a broadcast is in flight and all units request
        @(negedge clk);
        drive(4'b1111, 16'h4321, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        @(posedge clk);
        #1;
        chk("midrst_pre_bcen", {31'd0, BCEN}, 32'd1);
        chk("midrst_pre_ptr",  {30'd0, ptr}, 32'd2);
        #1;
        nRST = 1'b1;
        #1;
        chk("midrst_bcen",    {31'd0, BCEN}, 32'd0);
        chk("midrst_bclabel", {28'd0, BClabel}, 32'd0);
        chk("midrst_bcdata",  BCdata, 32'd0);
        chk("midrst_ptr",     {30'd0, ptr}, 32'd0);
        chk("midrst_err",     {31'd0, err_label0}, 32'd0);
        chk("midrst_accept",  {28'd0, accept}, 32'd0);
        @(negedge clk);
        nRST = 1'b0;
        #1;
        chk("postrst_accept", {28'd0, accept}, 32'd1);
        @(posedge clk);
        #1;
        chk("postrst_bclabel", {28'd0, BClabel}, 32'd1);
        chk("postrst_ptr",     {30'd0, ptr}, 32'd1);

        // Randomized traffic against a behavioural model
        do_reset();
        m_ptr = 0;
        m_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0]  rq;
            logic [3:0]  lb [4];
            logic [31:0] dt [4];
            logic        st;
            int          win;
            logic [3:0]  exp_acc;
            rq = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < 4; i++) begin
                lb[i] = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                dt[i] = $urandom;
            end
            @(negedge clk);
            drive(rq, {lb[3], lb[2], lb[1], lb[0]}, st, dt[0], dt[1], dt[2], dt[3]);
            win = -1;
            if (!st) begin
                for (int k = 0; k < 4; k++) begin
                    int u;
                    u = (m_ptr + k) % 4;
                    if (win < 0 && rq[u] && lb[u] != 4'd0) win = u;
                end
            end
            exp_acc = (win >= 0) ? (4'b0001 << win) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (rq[i] && lb[i] == 4'd0) m_err = 1'b1;
            end
            #1;
            chk("rnd_accept", {28'd0, accept}, {28'd0, exp_acc});
            @(posedge clk);
            #1;
            if (win >= 0) m_ptr = (win + 1) % 4;
            chk("rnd_bcen", {31'd0, BCEN}, (win >= 0) ? 32'd1 : 32'd0);
            chk("rnd_bclabel", {28'd0, BClabel}, (win >= 0) ? {28'd0, lb[win]} : 32'd0);
            chk("rnd_bcdata", BCdata, (win >= 0) ? dt[win] : 32'd0);
            chk("rnd_ptr", {30'd0, ptr}, 32'(m_ptr));
            chk("rnd_err", {31'd0, err_label0}, {31'd0, m_err});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sequential round-robin arbiter and broadcast register for the common data bus (CDB).
- Up to NREQ functional-unit result ports (index 0 alu, 1 mul, 2 div, 3 load/store) raise require; exactly one is accepted per cycle.
- The winner's label/data is registered and broadcast on BCEN/BClabel/BCdata the next cycle to the register file, reservation stations and queues.
- Replaces the purely combinational require/accept helper plus CDB mux: adds fairness, stall and error detection.

Parameters:
- DATA_W, 32, broadcast data width
- LABEL_W, 4, reservation-station label width; label 0 means "no producer"
- NREQ, 4, number of requesters; the implementation supports exactly 4

Ports:
- clk  input  1  clock, rising edge
- nRST  input  1  asynchronous reset, active-high: asserted at 1 (port name kept as in the codebase)
- require  input  NREQ  per-unit request; bit i = unit i holds a finished result
- data0..data3  input  DATA_W each  result data of unit i
- label0..label3  input  LABEL_W each  result label of unit i
- bc_stall  input  1  1 = issue no grant this cycle
- accept  output  NREQ  one-hot grant, combinational in the same cycle as require
- BCEN  output  1  broadcast valid, registered
- BClabel  output  LABEL_W  broadcast label, registered
- BCdata  output  DATA_W  broadcast data, registered
- ptr  output  2  current highest-priority index (debug)
- err_label0  output  1  sticky: a request arrived carrying label 0

Behaviour:
- Reset (nRST=1, asynchronous):
  - ptr=0, BCEN=0, BClabel=0, BCdata=0, err_label0=0.
  - accept is forced to 0 while nRST=1.
- Eligibility: request i is eligible iff require[i]=1, label_i!=0, bc_stall=0.
- Grant selection (combinational):
  - Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first eligible index w wins and accept[w]=1.
  - All other accept bits are 0.
  - If nothing is eligible, accept=0.
- At each rising edge:
  - On a grant: BCEN<=1, BClabel<=label_w, BCdata<=data_w, ptr<=(w+1) mod 4.
  - With no grant: BCEN<=0, BClabel<=0, BCdata<=0; ptr unchanged.
- Latency: accept in cycle t, broadcast visible during cycle t+1 only. Back-to-back grants give continuous BCEN=1.
- Requester handshake:
  - A unit keeps require, data and label stable until it samples accept=1 at an edge.
  - It then drops require, or presents its next result, in the following cycle.
  - The arbiter does not latch requests; an unaccepted request must be held.
- Label 0:
  - require[i]=1 with label_i=0 is never granted.
  - err_label0<=1 at the next edge and stays set until reset.
  - Other requesters are unaffected.
- bc_stall=1: accept=0 and the next-cycle broadcast is idle. ptr is held, so pending requests resume in the same order.
- Fairness: any continuously held eligible request is granted within 4 non-stalled cycles.
- Reset mid-operation: an in-flight broadcast is dropped (BCEN->0 immediately). Units must re-request after reset.
- No combinational path exists from the data/label inputs to the BC* outputs.

Test Plan:
- Reset, then require=0001, label0=3, data0=0x11 -> same cycle accept=0001; next cycle BCEN=1, BClabel=3, BCdata=0x11, ptr=1; following cycle BCEN=0.
- ptr=0, require=1111 held (each unit drops after its accept), labels 1,2,3,4 -> accepts 0001,0010,0100,1000 in 4 consecutive cycles; BClabel sequence 1,2,3,4 with BCEN=1 for 4 cycles; ptr ends 0.
- ptr=2, require=0011 -> accept=0001 (wraps), ptr becomes 1; next cycle with require=0010 only -> accept=0010, ptr=2.
- require=0100 held with bc_stall=1 for 3 cycles -> accept=0, BCEN=0, ptr unchanged; bc_stall=0 -> accept=0100, broadcast next cycle.
- require=0010, label1=0 -> accept=0, BCEN stays 0, err_label0=1 after the edge and remains 1; a later valid require=0001 is still granted normally.
- nRST pulsed high while BCEN=1 and require=1111 -> BCEN/BClabel/BCdata/ptr immediately 0, accept=0 during reset; after release grant order restarts at index 0.
